// File: rtl/serial_mem_loader_pkg.sv
// Shared definitions for the serial memory loader.
// - Command and reply byte values of the host protocol.
// - Parser/memory state encoding for the top level.
// - Transmit sequencer state encoding.
// - Width of the inter-byte timeout counter.
package serial_mem_loader_pkg;

    localparam logic [7:0] CMD_W   = 8'h57;   // 'W' write word
    localparam logic [7:0] CMD_R   = 8'h52;   // 'R' read word
    localparam logic [7:0] CMD_G   = 8'h47;   // 'G' release the CPU
    localparam logic [7:0] RSP_K   = 8'h4B;   // 'K' acknowledge
    localparam logic [7:0] RSP_ERR = 8'h3F;   // '?' unknown command

    // Holds TIMEOUT-1 for the 100 ms default at 58 MHz.
    localparam int TO_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RDWAIT,
        ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GUARD
    } tx_state_t;

endpackage

// File: rtl/serial_tx_seq.sv
// Reply transmitter: shifts out 1 or 4 bytes, MSB first, over rs232out.
// Ports:
//   clock, rst     system clock, synchronous active-high reset
//   start          load data/four and begin sending (accepted only when idle)
//   four           1 = send all 4 bytes of data, 0 = send data[31:24] only
//   data           reply word
//   busy           transmitter busy
//   tx_w           one-cycle transmit strobe
//   tx_d           byte to transmit, held from its strobe until the next one
//   done           pulses in the strobe cycle of the last byte
module serial_tx_seq
    import serial_mem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic        four,
    input  logic [31:0] data,
    input  logic        busy,
    output logic        tx_w,
    output logic [7:0]  tx_d,
    output logic        done
);

    tx_state_t   st, st_n;
    logic [31:0] shreg;
    logic [2:0]  left;

    // Strobe and byte are registered together, so the strobe cycle is
    // always the single GUARD cycle; busy is sampled again only after it.
    always_comb begin
        st_n = st;
        done = 1'b0;
        case (st)
            TX_IDLE:  if (start) st_n = TX_SEND;
            TX_SEND:  if (!busy) st_n = TX_GUARD;
            TX_GUARD: begin
                if (left == 3'd0) begin
                    done = 1'b1;
                    st_n = TX_IDLE;
                end else begin
                    st_n = TX_SEND;
                end
            end
            default:  st_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            st    <= TX_IDLE;
            shreg <= 32'h0;
            left  <= 3'd0;
            tx_w  <= 1'b0;
            tx_d  <= 8'h00;
        end else begin
            st   <= st_n;
            tx_w <= 1'b0;
            if (st == TX_IDLE && start) begin
                shreg <= data;
                left  <= four ? 3'd4 : 3'd1;
            end
            if (st == TX_SEND && !busy) begin
                tx_w  <= 1'b1;
                tx_d  <= shreg[31:24];
                shreg <= {shreg[23:0], 8'h00};
                left  <= left - 3'd1;
            end
        end
    end

endmodule

// File: rtl/serial_mem_loader.sv
// Serial-line memory initiator: parses W/R/G commands from rs232in, issues
// single word reads/writes on the mem_* interface and replies on rs232out.
// hold keeps the CPU in reset until 'G' is acknowledged; after that the
// block is inert until rst.
// Ports:
//   clock, rst                      clock, synchronous active-high reset
//   rs232in_attention/_data         received byte strobe and value
//   rs232out_busy/_w/_d             transmitter handshake
//   mem_*                           word-addressed initiator interface
//   hold                            1 = loader owns bus, CPU held in reset
module serial_mem_loader
    import serial_mem_loader_pkg::*;
#(
    parameter logic [1:0] ID         = 2'd3,
    parameter int         TIMEOUT    = 5_800_000,
    parameter logic       START_HOLD = 1'b1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        rs232in_attention,
    input  logic [7:0]  rs232in_data,
    input  logic        rs232out_busy,
    output logic        rs232out_w,
    output logic [7:0]  rs232out_d,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,
    output logic        hold
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [1:0]      byte_cnt;
    logic [23:0]     addr_sr;
    logic [23:0]     data_sr;
    logic            is_write;
    logic            is_go;
    logic [TO_W-1:0] to_cnt;
    logic            take;
    logic            collecting;
    logic            timed_out;
    logic            tx_start;
    logic            tx_four;
    logic [31:0]     tx_data;
    logic            tx_done;

    assign mem_id            = ID;
    assign mem_writedatamask = 4'hF;
    // Requests come straight from the state register, so they are stable
    // through any stall and can never overlap.
    assign mem_write         = (state == ST_WR);
    assign mem_read          = (state == ST_RD);

    // Bytes are only taken while owning the bus; other states drop them.
    assign take       = rs232in_attention & hold;
    assign collecting = (state == ST_ADDR) || (state == ST_DATA);
    // A byte arriving in the expiring cycle still counts.
    assign timed_out  = collecting && (to_cnt == TO_LAST) && !rs232in_attention;

    always_comb begin
        state_n  = state;
        tx_start = 1'b0;
        tx_four  = 1'b0;
        tx_data  = 32'h0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    case (rs232in_data)
                        CMD_W, CMD_R: state_n = ST_ADDR;
                        CMD_G: begin
                            tx_start = 1'b1;
                            tx_data  = {RSP_K, 24'h0};
                            state_n  = ST_SEND;
                        end
                        default: begin
                            tx_start = 1'b1;
                            tx_data  = {RSP_ERR, 24'h0};
                            state_n  = ST_SEND;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                if (take && byte_cnt == 2'd3) state_n = is_write ? ST_DATA : ST_RD;
                else if (timed_out)           state_n = ST_IDLE;
            end
            ST_DATA: begin
                if (take && byte_cnt == 2'd3) state_n = ST_WR;
                else if (timed_out)           state_n = ST_IDLE;
            end
            ST_WR: begin
                if (!mem_waitrequest) begin
                    tx_start = 1'b1;
                    tx_data  = {RSP_K, 24'h0};
                    state_n  = ST_SEND;
                end
            end
            ST_RD: if (!mem_waitrequest) state_n = ST_RDWAIT;
            ST_RDWAIT: begin
                // The sequencer's shift register doubles as the capture register.
                if (mem_readdataid == ID) begin
                    tx_start = 1'b1;
                    tx_four  = 1'b1;
                    tx_data  = mem_readdata;
                    state_n  = ST_SEND;
                end
            end
            ST_SEND: if (tx_done) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_cnt      <= 2'd0;
            addr_sr       <= 24'h0;
            data_sr       <= 24'h0;
            is_write      <= 1'b0;
            is_go         <= 1'b0;
            to_cnt        <= '0;
            mem_address   <= 30'h0;
            mem_writedata <= 32'h0;
            hold          <= START_HOLD;
        end else begin
            state <= state_n;
            if (take && state == ST_IDLE) begin
                byte_cnt <= 2'd0;
                is_write <= (rs232in_data == CMD_W);
                is_go    <= (rs232in_data == CMD_G);
            end
            // byte_cnt wraps from 3 to 0, ready for the data field.
            if (take && collecting) byte_cnt <= byte_cnt + 2'd1;
            if (take && state == ST_ADDR) begin
                addr_sr <= {addr_sr[15:0], rs232in_data};
                if (byte_cnt == 2'd3) mem_address <= {addr_sr, rs232in_data[7:2]};
            end
            if (take && state == ST_DATA) begin
                data_sr <= {data_sr[15:0], rs232in_data};
                if (byte_cnt == 2'd3) mem_writedata <= {data_sr, rs232in_data};
            end
            if (rs232in_attention) to_cnt <= '0;
            else if (collecting)   to_cnt <= to_cnt + 1'b1;
            else                   to_cnt <= '0;
            if (state == ST_SEND && tx_done && is_go) hold <= 1'b0;
        end
    end

    serial_tx_seq u_tx (
        .clock (clock),
        .rst   (rst),
        .start (tx_start),
        .four  (tx_four),
        .data  (tx_data),
        .busy  (rs232out_busy),
        .tx_w  (rs232out_w),
        .tx_d  (rs232out_d),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_serial_mem_loader.sv
// Bench for serial_mem_loader: host byte driver, busy-modelling transmitter
// sink, stalling memory responder and a command-level reference model.
module tb_serial_mem_loader;

    localparam logic [1:0] ID = 2'd3;
    localparam int         TO = 200;

    typedef struct packed {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        rs232in_attention = 1'b0;
    logic [7:0]  rs232in_data = 8'h00;
    logic        rs232out_busy = 1'b0;
    logic        rs232out_w;
    logic [7:0]  rs232out_d;
    logic        mem_waitrequest = 1'b0;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata = 32'h0;
    logic [1:0]  mem_readdataid = 2'd0;
    logic        hold;

    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_mode = -1;
    int   act_cnt = 0;
    logic [7:0]  rx_q[$];
    req_t        req_q[$];
    logic [31:0] resp_mem[logic [29:0]];
    logic [31:0] model_mem[logic [29:0]];

    always #5 clock = ~clock;

    serial_mem_loader #(.ID(ID), .TIMEOUT(TO), .START_HOLD(1'b1)) dut (
        .clock             (clock),
        .rst               (rst),
        .rs232in_attention (rs232in_attention),
        .rs232in_data      (rs232in_data),
        .rs232out_busy     (rs232out_busy),
        .rs232out_w        (rs232out_w),
        .rs232out_d        (rs232out_d),
        .mem_waitrequest   (mem_waitrequest),
        .mem_id            (mem_id),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid),
        .hold              (hold)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_rd(input logic [29:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [29:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    // Transmitter sink: records bytes, goes busy for a random while per byte.
    initial begin
        int   bcnt = 0;
        logic prev_w = 1'b0;
        forever begin
            @(negedge clock);
            if (rs232out_w) begin
                check("busy_at_strobe", 64'(rs232out_busy), 64'd0);
                check("strobe_width", 64'(prev_w), 64'd0);
                rx_q.push_back(rs232out_d);
                bcnt = $urandom_range(1, 4);
            end else if (bcnt > 0) begin
                bcnt--;
            end
            rs232out_busy = (bcnt > 0);
            prev_w = rs232out_w;
        end
    end

    // Memory responder: stalls each request, answers reads after a delay,
    // preceded by a foreign-id beat; idle cycles carry random id-0 data.
    initial begin
        logic        in_req = 1'b0;
        int          stall = 0;
        int          rd_timer = -1;
        logic [29:0] rd_addr = 30'h0;
        req_t        cur = '0;
        forever begin
            @(negedge clock);
            mem_readdataid = 2'd0;
            mem_readdata   = $urandom;
            if (rd_timer == 0) begin
                mem_readdataid = ID;
                mem_readdata   = resp_rd(rd_addr);
            end else if (rd_timer == 1) begin
                mem_readdataid = 2'd1;
            end
            if (rd_timer >= 0) rd_timer--;
            if (mem_read || mem_write) begin
                act_cnt++;
                check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
                if (!in_req) begin
                    in_req = 1'b1;
                    cur = {mem_write, mem_address, mem_writedata};
                    stall = (stall_mode >= 0) ? stall_mode : $urandom_range(0, 3);
                end else begin
                    check("req_stable", 64'({mem_write, mem_address, mem_writedata}), 64'(cur));
                end
                if (stall > 0) begin
                    mem_waitrequest = 1'b1;
                    stall--;
                end else begin
                    mem_waitrequest = 1'b0;
                    req_q.push_back(cur);
                    in_req = 1'b0;
                    if (cur.wr) resp_mem[cur.addr] = cur.data;
                    else begin
                        rd_timer = 5;
                        rd_addr  = cur.addr;
                    end
                end
            end else begin
                in_req = 1'b0;
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clock);
        rs232in_data = b;
        rs232in_attention = 1'b1;
        @(negedge clock);
        rs232in_attention = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        send_byte(op, $urandom_range(0, 2));
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 3; i >= 0; i--)
                send_byte(addr[8*i +: 8], (i == 0 && op == 8'h52) ? 0 : $urandom_range(0, 2));
            if (op == 8'h57)
                for (int i = 3; i >= 0; i--)
                    send_byte(data[8*i +: 8], (i == 0) ? 0 : $urandom_range(0, 2));
        end
    endtask

    task automatic expect_bytes(input string tag, input logic [31:0] exp, input int n);
        int t = 0;
        logic [7:0] got;
        while (rx_q.size() < n && t < 400) begin
            @(negedge clock);
            t++;
        end
        repeat (20) @(negedge clock);
        check({tag, "_reply_count"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check({tag, "_reply_byte"}, 64'(got), (n == 1) ? 64'(exp[7:0]) : 64'(exp[8*(3-i) +: 8]));
        end
        rx_q.delete();
    endtask

    task automatic expect_req(input string tag, input logic wr, input logic [29:0] a, input logic [31:0] d);
        req_t got;
        check({tag, "_req_count"}, 64'(req_q.size()), 64'd1);
        if (req_q.size() > 0) begin
            got = req_q.pop_front();
            check({tag, "_req_kind_addr"}, 64'({got.wr, got.addr}), 64'({wr, a}));
            if (wr) check({tag, "_req_data"}, 64'(got.data), 64'(d));
        end
        req_q.delete();
    endtask

    // Command-level reference: memory image plus expected reply/request.
    task automatic do_txn(input string tag, input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        send_cmd(op, addr, data);
        if (op == 8'h57) begin
            check({tag, "_latency"}, 64'(mem_write), 64'd1);
            model_mem[addr[31:2]] = data;
            expect_bytes(tag, 32'h4B, 1);
            expect_req(tag, 1'b1, addr[31:2], data);
        end else if (op == 8'h52) begin
            check({tag, "_latency"}, 64'(mem_read), 64'd1);
            expect_bytes(tag, model_rd(addr[31:2]), 4);
            expect_req(tag, 1'b0, addr[31:2], 32'h0);
        end else begin
            expect_bytes(tag, 32'h3F, 1);
            check({tag, "_no_req"}, 64'(req_q.size()), 64'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          act0;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] d;

        repeat (3) @(negedge clock);
        check("rst_hold", 64'(hold), 64'd1);
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_w", 64'(rs232out_w), 64'd0);
        check("rst_d", 64'(rs232out_d), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", 64'(mem_writedata), 64'd0);
        check("mask", 64'(mem_writedatamask), 64'hF);
        check("mem_id", 64'(mem_id), 64'(ID));
        rst = 1'b0;

        // Directed write with three stall cycles.
        stall_mode = 3;
        send_cmd(8'h57, 32'h0000_0104, 32'hDEAD_BEEF);
        check("wr_addr", 64'(mem_address), 64'h41);
        check("wr_data", 64'(mem_writedata), 64'hDEAD_BEEF);
        n = 0;
        while (mem_write && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("wr_held_cycles", 64'(n), 64'd4);
        model_mem[30'h41] = 32'hDEAD_BEEF;
        expect_bytes("wr", 32'h4B, 1);
        expect_req("wr", 1'b1, 30'h41, 32'hDEAD_BEEF);
        stall_mode = -1;

        // Directed read with injected memory contents.
        resp_mem[30'h41]  = 32'h1234_5678;
        model_mem[30'h41] = 32'h1234_5678;
        do_txn("rd", 8'h52, 32'h0000_0104, 32'h0);

        do_txn("unknown", 8'h41, 32'h0, 32'h0);

        // Partial write abandoned by the inter-byte timeout.
        send_byte(8'h57, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        repeat (TO + 10) @(negedge clock);
        check("to_no_reply", 64'(rx_q.size()), 64'd0);
        check("to_no_req", 64'(req_q.size()), 64'd0);
        do_txn("to_rd", 8'h52, 32'h0, 32'h0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom & 32'hC000_003F;
            d = $urandom;
            case ($urandom_range(0, 4))
                0, 1: op = 8'h57;
                2, 3: op = 8'h52;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h57 || op == 8'h52 || op == 8'h47) op = 8'($urandom_range(0, 255));
                end
            endcase
            do_txn("rand", op, a, d);
        end

        // Release: 'K' then hold drops the following cycle.
        send_byte(8'h47, 0);
        n = 0;
        while (!rs232out_w && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("go_strobe_seen", 64'(rs232out_w), 64'd1);
        check("go_hold_at_strobe", 64'(hold), 64'd1);
        @(negedge clock);
        check("go_hold_after", 64'(hold), 64'd0);
        expect_bytes("go", 32'h4B, 1);
        act0 = act_cnt;
        send_cmd(8'h57, 32'h0000_0010, 32'hCAFE_F00D);
        repeat (50) @(negedge clock);
        check("inert_mem", 64'(act_cnt), 64'(act0));
        check("inert_tx", 64'(rx_q.size()), 64'd0);
        check("inert_hold", 64'(hold), 64'd0);

        // Re-arm, then reset in the middle of a stalled read.
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("rearm_hold", 64'(hold), 64'd1);
        stall_mode = 1000;
        send_cmd(8'h52, 32'h0000_0020, 32'h0);
        check("midrd_read_up", 64'(mem_read), 64'd1);
        repeat (2) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("midrd_read_drop", 64'(mem_read), 64'd0);
        check("midrd_hold", 64'(hold), 64'd1);
        check("midrd_no_req", 64'(req_q.size()), 64'd0);
        stall_mode = -1;
        repeat (3) @(negedge clock);
        do_txn("after_rst", 8'h52, 32'h0000_0104, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
